uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte-stream requesters, for example the case-converter FIFO output, a status/banner generator and a debug dump.
- Uses round-robin arbitration with message locking. Once granted, a requester keeps the transmitter until it sends a byte flagged last, or until its stream stalls for TIMEOUT cycles.
- Sits between the requesters and the uart_tx data/valid/ready interface.
- Drives a registered single-entry holding stage toward the transmitter.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: data width per byte.
- TIMEOUT, 1024: stall cycles allowed while locked before the grant is forcibly released. 0 disables the watchdog.
- GW, $clog2(NUM_REQ): width of the grant index (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*WIDTH  requester i byte at [i*WIDTH +: WIDTH]
- req_last  in  NUM_REQ  byte is final of its message
- req_ready  out  NUM_REQ  per-requester accept; combinational
- tx_data  out  WIDTH  byte to uart_tx; registered
- tx_valid  out  1  holding register full; registered
- tx_ready  in  1  uart_tx idle/accepting
- grant_id  out  GW  index of the locked requester; registered
- busy  out  1  1 while in the LOCK state
- timeout_evt  out  1  one-cycle pulse when the watchdog releases a grant

Behaviour:
- Reset values (async): state=IDLE, rr_ptr=0, grant_id=0, tx_valid=0, tx_data=0, busy=0, timeout_evt=0, stall_cnt=0, last_pend=0, req_ready=0.
- Transfer to uart_tx: occurs in any cycle with tx_valid && tx_ready. tx_valid then clears on the next edge; tx_data is held stable while tx_valid=1.
- State IDLE:
  - If any req_valid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register grant_id = winner and go to LOCK.
  - No byte is accepted in the arbitration cycle (one-cycle grant latency).
- State LOCK, byte acceptance:
  - req_ready[grant_id] = !tx_valid && !last_pend. All other req_ready bits are 0.
  - On req_valid[g] && req_ready[g], load tx_data = byte, set tx_valid=1 and last_pend = req_last[g].
  - At most one byte is accepted per cycle.
  - No new byte is accepted until the holding register drains, so there is no bypass.
- State LOCK, end of message:
  - When last_pend=1 and the holding byte transfers, clear last_pend, set rr_ptr = grant_id+1 (wrapping at NUM_REQ) and return to IDLE.
  - The arbiter sees the next request one cycle later.
- Watchdog (TIMEOUT>0):
  - stall_cnt increments each LOCK cycle with tx_valid=0 && last_pend=0 && !req_valid[g].
  - stall_cnt clears on any accepted byte and on entering LOCK.
  - When stall_cnt reaches TIMEOUT-1 and increments again, pulse timeout_evt for one cycle, advance rr_ptr as for end of message, and go to IDLE.
  - Release is never taken while tx_valid=1; the pending byte always completes.
- Requesters ignored while locked: req_valid from non-granted requesters has no effect. They must hold valid and data until they receive ready.
- Simultaneous events: a transfer and a new acceptance cannot coincide, because ready requires !tx_valid. A request arriving in the same cycle as return to IDLE is arbitrated in the next cycle.
- Registered outputs: busy and grant_id are registered. grant_id retains its last value while in IDLE.
- Async reset mid-message: clears everything immediately.
  - A byte in the holding register is dropped.
  - The requester sees req_ready=0 and must restart its message.
- Width rules:
  - rr_ptr wrap: NUM_REQ-1 goes to 0; for non-power-of-2 NUM_REQ, wrap explicitly and never by overflow.
  - stall_cnt is $clog2(TIMEOUT+1) bits and saturates.

Test Plan:
- Single message: requester 1 sends 0x48,0x49(last), tx_ready always 1 -> grant_id=1 one cycle after valid; tx_data 0x48 then 0x49, each valid one cycle; then IDLE, busy=0.
- Contention and round-robin order: all four requesters valid from reset, each with a 2-byte message -> messages complete in order 0,1,2,3. Requester 0 valid again afterwards -> order continues 0.
- Message locking: while requester 2 is locked mid-message, requester 0 asserts valid -> req_ready[0] stays 0 and no byte from 0 interleaves; 0 is granted only after 2's last byte transfers.
- Backpressure: tx_ready held low 500 cycles with tx_valid=1 -> tx_data stable, req_ready all 0, no timeout_evt. tx_ready returns -> exactly one transfer.
- Watchdog: TIMEOUT=16, requester 3 sends one non-last byte then drops valid -> timeout_evt pulses exactly 17 cycles after the byte's transfer; state returns to IDLE; requester 0 is granted next.
- Reset mid-operation: assert rst_n low asynchronously with tx_valid=1 -> tx_valid, busy, req_ready go 0 immediately. After release, a fresh message from requester 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter that shares one uart_tx among NUM_REQ
// byte-stream requesters through a registered single-entry holding stage.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     timeout_evt
);

  localparam int            SW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [GW-1:0] LAST_IDX   = GW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    winner;
  logic [GW-1:0]    ptr_after_grant;
  logic             any_valid;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             last_pend;
  logic [SW-1:0]    stall_cnt;
  logic             xfer;
  logic             accept;
  logic             msg_done;
  logic             stall_tick;
  logic             wd_fire;

  // Two passes: indices at or above rr_ptr override those below, lowest wins in each.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (GW'(j) < rr_ptr)) begin
        winner    = GW'(j);
        any_valid = 1'b1;
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (GW'(j) >= rr_ptr)) begin
        winner    = GW'(j);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer            = tx_valid && tx_ready;
  assign accept          = (state == LOCK) && g_valid && !tx_valid && !last_pend;
  assign msg_done        = (state == LOCK) && last_pend && xfer;
  assign stall_tick      = (state == LOCK) && !tx_valid && !last_pend && !g_valid;
  assign wd_fire         = (TIMEOUT > 0) && stall_tick && (stall_cnt == STALL_LAST);
  assign ptr_after_grant = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = LOCK;
      LOCK:    if (msg_done || wd_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the locked requester may see ready, and only while the holding stage is empty.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == LOCK) && (grant_id == GW'(i)) && !tx_valid && !last_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      timeout_evt <= 1'b0;
      stall_cnt   <= '0;
      last_pend   <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      busy        <= (state_nxt == LOCK);
      if (xfer) tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id  <= winner;
            stall_cnt <= '0;
          end
        end
        LOCK: begin
          if (accept) begin
            tx_data   <= g_data;
            tx_valid  <= 1'b1;
            last_pend <= g_last;
            stall_cnt <= '0;
          end else if (msg_done) begin
            last_pend <= 1'b0;
            rr_ptr    <= ptr_after_grant;
          end else if (wd_fire) begin
            timeout_evt <= 1'b1;
            rr_ptr      <= ptr_after_grant;
            stall_cnt   <= '0;
          end else if (stall_tick && (stall_cnt != {SW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
